regfile_access_ctrl: RTL

//  Initiator for the dual-port 16x16 register file: turns issued instructions (src1/src2/dst) into

---
 rtl/regfile_access_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/regfile_access_ctrl.sv
// Issue/writeback initiator for a dual-port register file: busy-bit scoreboard,
// bounded outstanding-destination counter and a valid/ready operand stage.
module regfile_access_ctrl #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // issue side
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [ID_W-1:0]   iss_src1,
  input  logic [ID_W-1:0]   iss_src2,
  input  logic              iss_use_src2,
  input  logic [ID_W-1:0]   iss_dst,
  // operand side
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ID_W-1:0]   op_dst,
  // result side
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [ID_W-1:0]   res_dst,
  input  logic [DATA_W-1:0] res_data,
  // register file
  output logic              rf_rd1,
  output logic              rf_wn1,
  output logic              rf_rd2,
  output logic              rf_wn2,
  output logic [ID_W-1:0]   rf_id1,
  output logic [ID_W-1:0]   rf_id2,
  output logic [DATA_W-1:0] rf_wdata1,
  output logic [DATA_W-1:0] rf_wdata2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2
);

  localparam int unsigned NREG  = 1 << ID_W;
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_READ    = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;

  logic [1:0]        state_q,    state_d;
  logic [NREG-1:0]   busy_q,     busy_d;
  logic [CNT_W-1:0]  out_cnt_q,  out_cnt_d;
  logic [ID_W-1:0]   src1_q,     src1_d;
  logic [ID_W-1:0]   src2_q,     src2_d;
  logic              use2_q,     use2_d;
  logic [ID_W-1:0]   dst_q,      dst_d;
  logic              op_valid_q, op_valid_d;
  logic [DATA_W-1:0] op_a_q,     op_a_d;
  logic [DATA_W-1:0] op_b_q,     op_b_d;
  logic [ID_W-1:0]   op_dst_q,   op_dst_d;

  logic hazard;
  logic iss_fire;
  logic res_fire;
  logic cnt_dec;

  assign op_valid = op_valid_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_dst   = op_dst_q;

  // Next-state, scoreboard and register-file strobe logic
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    out_cnt_d  = out_cnt_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    use2_d     = use2_q;
    dst_d      = dst_q;
    op_valid_d = op_valid_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_dst_d   = op_dst_q;
    iss_ready  = 1'b0;
    iss_fire   = 1'b0;
    res_ready  = (state_q != ST_READ);
    res_fire   = 1'b0;
    cnt_dec    = 1'b0;
    rf_rd1     = 1'b0;
    rf_wn1     = 1'b0;
    rf_rd2     = 1'b0;
    rf_wn2     = 1'b0;
    rf_id1     = '0;
    rf_id2     = '0;
    rf_wdata1  = '0;
    rf_wdata2  = '0;

    hazard = busy_q[iss_src1] | (iss_use_src2 & busy_q[iss_src2]) | busy_q[iss_dst];

    case (state_q)
      ST_IDLE: begin
        iss_ready = ~hazard & (out_cnt_q < CNT_W'(MAX_OUT));
        if (iss_valid && iss_ready) begin
          iss_fire = 1'b1;
          src1_d   = iss_src1;
          src2_d   = iss_src2;
          use2_d   = iss_use_src2;
          dst_d    = iss_dst;
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        rf_rd1     = 1'b1;
        rf_id1     = src1_q;
        rf_rd2     = use2_q;
        rf_id2     = src2_q;
        op_a_d     = rf_rdata1;
        op_b_d     = use2_q ? rf_rdata2 : DATA_W'(0);
        op_dst_d   = dst_q;
        op_valid_d = 1'b1;
        state_d    = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (op_ready) begin
          op_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        op_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase

    // Port 2 is free for writeback whenever the FSM is not reading operands
    if (res_valid && res_ready) begin
      res_fire  = 1'b1;
      rf_rd2    = 1'b0;
      rf_wn2    = 1'b1;
      rf_id2    = res_dst;
      rf_wdata2 = res_data;
    end

    // Set before clear so a coincident clear on the same bit wins
    if (iss_fire) busy_d[iss_dst] = 1'b1;
    if (res_fire) begin
      cnt_dec         = busy_q[res_dst];
      busy_d[res_dst] = 1'b0;
    end

    out_cnt_d = out_cnt_q + CNT_W'(iss_fire) - CNT_W'(cnt_dec);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= '0;
      out_cnt_q  <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      use2_q     <= 1'b0;
      dst_q      <= '0;
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_dst_q   <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      out_cnt_q  <= out_cnt_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      use2_q     <= use2_d;
      dst_q      <= dst_d;
      op_valid_q <= op_valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_dst_q   <= op_dst_d;
    end
  end

endmodule
